// File: rtl/rom_access_arbiter_if.sv
// rtl/rom_access_arbiter_if.sv - request/response and ROM bus bundle for the ROM access arbiter
//
// Purpose: groups both requester channels and the ROM-side bus of rom_access_arbiter.
// Signals:
//   req<p>_valid/addr  requester read request (p = 0 fetch, 1 loader/debug)
//   req<p>_ready       request accepted this cycle
//   rsp<p>_valid/data/err  one-cycle response, err = address outside ROM window
//   rom_en/rom_addr    ROM read strobe and word address
//   rom_data           ROM read data, valid the cycle after rom_en
// Modports: slave = arbiter side, master = requester/ROM side.

interface rom_access_arbiter_if #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ROM_ADDR_BITS = 10
);
  logic                     req0_valid;
  logic [ADDR_W-1:0]        req0_addr;
  logic                     req0_ready;
  logic                     rsp0_valid;
  logic [DATA_W-1:0]        rsp0_data;
  logic                     rsp0_err;

  logic                     req1_valid;
  logic [ADDR_W-1:0]        req1_addr;
  logic                     req1_ready;
  logic                     rsp1_valid;
  logic [DATA_W-1:0]        rsp1_data;
  logic                     rsp1_err;

  logic                     rom_en;
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic [DATA_W-1:0]        rom_data;

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr, rom_data,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output rom_en, rom_addr
  );

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr, rom_data,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  rom_en, rom_addr
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// rtl/rom_access_arbiter.sv - two-port read arbiter for the synchronous program ROM
//
// Purpose: shares one 1-cycle-latency ROM between instruction fetch (port 0, fixed
// priority) and loader/debug reads (port 1, protected by an anti-starvation counter).
// At most one access is granted per cycle; addresses outside the ROM window get an
// error response without touching the ROM.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rom_access_arbiter_if.slave: both request/response channels and the ROM bus

module rom_access_arbiter #(
  parameter int ADDR_W              = 32,
  parameter int DATA_W              = 32,
  parameter int ROM_ADDR_BITS       = 10,
  parameter int ROM_ADDR_START_BITS = 0,
  parameter int MAX_WAIT            = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_access_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  // Window bounds are held one bit wider than the address so the top bound
  // cannot wrap when the window sits at the end of the address space.
  localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] WIN_LO = (ROM_ADDR_START_BITS == 0) ? '0 : (ONE << ROM_ADDR_START_BITS);
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ONE << ROM_ADDR_BITS) - ONE;

  typedef enum logic {PRI0, FORCE1} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_next;
  logic              rsp0_q;
  logic              rsp1_q;
  logic              err_q;

  logic              ready0;
  logic              ready1;
  logic              granted;
  logic [ADDR_W-1:0] grant_addr;
  logic [ADDR_W:0]   addr_x;
  logic              in_win;

  // Ready is forced low while reset is asserted so nothing is accepted or
  // presented to the ROM during reset.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (rst_n) begin
      if (state == FORCE1) begin
        ready1 = bus.req1_valid;
        ready0 = bus.req0_valid & ~bus.req1_valid;
      end else begin
        ready0 = bus.req0_valid;
        ready1 = bus.req1_valid & ~bus.req0_valid;
      end
    end
  end

  assign granted    = ready0 | ready1;
  assign grant_addr = ready1 ? bus.req1_addr : bus.req0_addr;
  assign addr_x     = {1'b0, grant_addr};

  generate
    if (ROM_ADDR_START_BITS == 0) begin : g_win_base0
      assign in_win = (addr_x <= WIN_HI);
    end else begin : g_win_offset
      assign in_win = (addr_x >= WIN_LO) && (addr_x <= WIN_HI);
    end
  endgenerate

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rom_en     = granted & in_win;
  assign bus.rom_addr   = (granted & in_win) ? grant_addr[ROM_ADDR_BITS-1:0] : '0;

  // Consecutive refused cycles of port 1; any gap in valid1 or an accept restarts it.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!bus.req1_valid || ready1) begin
      wait_cnt_next = '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt_next = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PRI0;
      wait_cnt <= '0;
      rsp0_q   <= 1'b0;
      rsp1_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      case (state)
        PRI0: begin
          // The refusal that brings the count to MAX_WAIT still loses to port 0;
          // the forced grant happens on the following cycle.
          if (wait_cnt_next == MAX_CNT) begin
            state <= FORCE1;
          end
        end
        FORCE1: begin
          if (!bus.req1_valid || ready1) begin
            state <= PRI0;
          end
        end
        default: state <= PRI0;
      endcase
      rsp0_q <= ready0;
      rsp1_q <= ready1;
      err_q  <= granted & ~in_win;
    end
  end

  // rom_data arrives one cycle after rom_en, so response data is steered from the
  // ROM output using the registered owner/err flags rather than being registered.
  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.rsp0_err   = rsp0_q & err_q;
  assign bus.rsp1_err   = rsp1_q & err_q;
  assign bus.rsp0_data  = (rsp0_q & ~err_q) ? bus.rom_data : '0;
  assign bus.rsp1_data  = (rsp1_q & ~err_q) ? bus.rom_data : '0;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb/tb_rom_access_arbiter.sv - randomized self-checking bench for rom_access_arbiter

module tb_rom_access_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 1'b0;
  logic        v1 = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] a1 = '0;

  // Instance 0: window at 0, MAX_WAIT 4. Instance 1: window at 0x1000, MAX_WAIT 2.
  rom_access_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ROM_ADDR_BITS(10)) ifa ();
  rom_access_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ROM_ADDR_BITS(10)) ifb ();

  rom_access_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_ADDR_BITS(10),
                       .ROM_ADDR_START_BITS(0), .MAX_WAIT(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  rom_access_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_ADDR_BITS(10),
                       .ROM_ADDR_START_BITS(12), .MAX_WAIT(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.req0_valid = v0;
  assign ifa.req0_addr  = a0;
  assign ifa.req1_valid = v1;
  assign ifa.req1_addr  = a1;
  assign ifb.req0_valid = v0;
  assign ifb.req0_addr  = a0;
  assign ifb.req1_valid = v1;
  assign ifb.req1_addr  = a1;

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return (32'(a) + 32'd7) * 32'h9E37_79B9;
  endfunction

  // Behavioural synchronous ROMs, one per instance.
  logic [31:0] romq0 = '0;
  logic [31:0] romq1 = '0;
  always @(posedge clk) begin
    if (ifa.rom_en) romq0 <= rom_word(ifa.rom_addr);
    if (ifb.rom_en) romq1 <= rom_word(ifb.rom_addr);
  end
  assign ifa.rom_data = romq0;
  assign ifb.rom_data = romq1;

  logic [1:0]  rdy0, rdy1, en, rv0, rv1, re0, re1;
  logic [9:0]  ra [2];
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  assign rdy0 = {ifb.req0_ready, ifa.req0_ready};
  assign rdy1 = {ifb.req1_ready, ifa.req1_ready};
  assign en   = {ifb.rom_en, ifa.rom_en};
  assign rv0  = {ifb.rsp0_valid, ifa.rsp0_valid};
  assign rv1  = {ifb.rsp1_valid, ifa.rsp1_valid};
  assign re0  = {ifb.rsp0_err, ifa.rsp0_err};
  assign re1  = {ifb.rsp1_err, ifa.rsp1_err};
  assign ra[0]  = ifa.rom_addr;
  assign ra[1]  = ifb.rom_addr;
  assign rd0[0] = ifa.rsp0_data;
  assign rd0[1] = ifb.rsp0_data;
  assign rd1[0] = ifa.rsp1_data;
  assign rd1[1] = ifb.rsp1_data;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: port 1 wins whenever it has been refused MAX_WAIT cycles in a row.
  int          mw  [2] = '{4, 2};
  longint      wlo [2] = '{0, 64'h1000};
  int          refused [2];
  bit          pv0 [2];
  bit          pv1 [2];
  bit          perr [2];
  logic [31:0] pdat [2];

  function automatic bit in_win(input int k, input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= wlo[k]) && (la <= wlo[k] + 1023);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      refused[k] = 0;
      pv0[k] = 0;
      pv1[k] = 0;
      perr[k] = 0;
      pdat[k] = '0;
    end
  endtask

  task automatic step(input bit nv0, input logic [31:0] na0, input bit nv1, input logic [31:0] na1);
    bit g0, g1, w;
    logic [31:0] ga;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rsp0_valid[%0d]", k), rv0[k], pv0[k]);
      check_eq($sformatf("rsp1_valid[%0d]", k), rv1[k], pv1[k]);
      check_eq($sformatf("rsp0_err[%0d]", k), re0[k], pv0[k] & perr[k]);
      check_eq($sformatf("rsp1_err[%0d]", k), re1[k], pv1[k] & perr[k]);
      check_eq($sformatf("rsp0_data[%0d]", k), rd0[k], (pv0[k] && !perr[k]) ? pdat[k] : 32'h0);
      check_eq($sformatf("rsp1_data[%0d]", k), rd1[k], (pv1[k] && !perr[k]) ? pdat[k] : 32'h0);
    end
    v0 = nv0; a0 = na0; v1 = nv1; a1 = na1;
    #1;
    for (int k = 0; k < 2; k++) begin
      g1 = nv1 && (refused[k] == mw[k] || !nv0);
      g0 = nv0 && !g1;
      ga = g1 ? na1 : na0;
      w  = (g0 || g1) && in_win(k, ga);
      check_eq($sformatf("req0_ready[%0d]", k), rdy0[k], g0);
      check_eq($sformatf("req1_ready[%0d]", k), rdy1[k], g1);
      check_eq($sformatf("rom_en[%0d]", k), en[k], w);
      check_eq($sformatf("rom_addr[%0d]", k), ra[k], w ? 10'(longint'(ga) - wlo[k]) : 10'h0);
      pv0[k]  = g0;
      pv1[k]  = g1;
      perr[k] = (g0 || g1) && !w;
      pdat[k] = rom_word(10'(longint'(ga) - wlo[k]));
      if (nv1 && !g1) refused[k] = (refused[k] < mw[k]) ? refused[k] + 1 : mw[k];
      else refused[k] = 0;
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return $urandom;
      1: return 32'($urandom_range(0, 1023));
      2: return 32'h3FF;
      3: return 32'h400;
      4: return 32'hFFF;
      5: return 32'h1000;
      6: return 32'h13FF;
      7: return 32'h1400;
      8: return 32'h1000 + 32'($urandom_range(0, 1023));
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  int p1_wins;

  initial begin
    model_clear();
    // Reset state with both requests pending.
    v0 = 1'b1; a0 = 32'h10; v1 = 1'b1; a1 = 32'h20;
    #3;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_ready0[%0d]", k), rdy0[k], 1'b0);
      check_eq($sformatf("rst_ready1[%0d]", k), rdy1[k], 1'b0);
      check_eq($sformatf("rst_rom_en[%0d]", k), en[k], 1'b0);
      check_eq($sformatf("rst_rom_addr[%0d]", k), ra[k], 10'h0);
      check_eq($sformatf("rst_rsp0[%0d]", k), {rv0[k], re0[k], rd0[k]}, 34'h0);
      check_eq($sformatf("rst_rsp1[%0d]", k), {rv1[k], re1[k], rd1[k]}, 34'h0);
    end
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Port 0 back-to-back, then out-of-window port 1, then window edges.
    step(1, 32'h3, 0, 0);
    step(1, 32'h4, 0, 0);
    step(0, 0, 1, 32'h400);
    step(1, 32'h0FFF, 0, 0);
    step(1, 32'h1000, 0, 0);
    step(1, 32'h13FF, 0, 0);
    step(1, 32'h1400, 0, 0);
    step(0, 0, 0, 0);

    // Continuous contention: instance 0 must give port 1 exactly 2 of 10 cycles.
    p1_wins = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h8 + 32'(i), 1, 32'h100 + 32'(i));
      if (rdy1[0]) p1_wins++;
    end
    check_eq("contention_p1_wins", 64'(p1_wins), 64'd2);

    // Port 1 drops valid right when it would be forced.
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h20, 1, 32'h30);
    step(1, 32'h21, 0, 0);
    step(1, 32'h22, 1, 32'h31);
    step(0, 0, 0, 0);

    // Reset mid-access: accepted request must not produce a response.
    step(1, 32'h10, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("midrst_rsp0[%0d]", k), {rv0[k], re0[k], rd0[k]}, 34'h0);
      check_eq($sformatf("midrst_ready0[%0d]", k), rdy0[k], 1'b0);
      check_eq($sformatf("midrst_rom_en[%0d]", k), en[k], 1'b0);
    end
    v0 = 1'b0; v1 = 1'b0;
    #5;
    rst_n = 1'b1;
    model_clear();
    step(1, 32'h5, 1, 32'h6);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 70, pick_addr(), $urandom_range(0, 99) < 70, pick_addr());
    end
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
